// File: rtl/prog_rom_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prog_rom_ctrl_if : fetch handshake and load port bundle           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface prog_rom_ctrl_if #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 10
);
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] address;
   logic                  rd_ready;
   logic                  rd_valid;
   logic                  rd_ack;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  rd_oob;
   logic                  load_en;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_clear;
   logic [ADDR_WIDTH:0]   prog_len;
   logic                  load_err;

   modport master (
      output rd_req, address, rd_ack, load_en, load_addr, load_data, load_clear,
      input  rd_ready, rd_valid, read_data, rd_oob, prog_len, load_err
   );

   modport slave (
      input  rd_req, address, rd_ack, load_en, load_addr, load_data, load_clear,
      output rd_ready, rd_valid, read_data, rd_oob, prog_len, load_err
   );
endinterface
`default_nettype wire

// File: rtl/prog_rom_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | prog_rom_ctrl : loadable instruction memory, registered fetch     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module prog_rom_ctrl #(
   parameter int                    DATA_WIDTH = 10,
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DEPTH      = 1024,
   parameter int                    INIT_LEN   = 0,
   parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 10'b0010000010
) (
   input  logic             clk,
   input  logic             rst_n,
   prog_rom_ctrl_if.slave   bus
);

   localparam int                  MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] c_init_len = (ADDR_WIDTH+1)'(INIT_LEN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_read_data;
   logic                  r_rd_oob;
   logic [ADDR_WIDTH:0]   r_prog_len;
   logic                  r_load_err;

   logic                  w_rd_ready;
   logic                  w_accept;
   logic                  w_in_bounds;
   logic                  w_load_ok;
   logic [ADDR_WIDTH:0]   w_load_len;
   logic [MEM_AW-1:0]     w_rd_idx;
   logic [MEM_AW-1:0]     w_wr_idx;

   assign w_rd_ready  = !bus.load_en && (!r_rd_valid || bus.rd_ack);
   assign w_accept    = bus.rd_req && w_rd_ready;
   assign w_in_bounds = ({1'b0, bus.address} < r_prog_len) &&
                        ({1'b0, bus.address} < c_depth);
   assign w_load_ok   = bus.load_en && ({1'b0, bus.load_addr} < c_depth);
   assign w_load_len  = {1'b0, bus.load_addr} + (ADDR_WIDTH+1)'(1);
   assign w_rd_idx    = bus.address[MEM_AW-1:0];
   assign w_wr_idx    = bus.load_addr[MEM_AW-1:0];

   // Storage is deliberately not reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_load_ok) begin
         mem[w_wr_idx] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid  <= 1'b0;
         r_read_data <= '0;
         r_rd_oob    <= 1'b0;
      end else if (w_accept) begin
         r_rd_valid  <= 1'b1;
         r_read_data <= w_in_bounds ? mem[w_rd_idx] : FILL_WORD;
         r_rd_oob    <= !w_in_bounds;
      end else if (bus.rd_ack) begin
         r_rd_valid  <= 1'b0;
      end
   end

   // A clear wins over the length growth of a simultaneous load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prog_len <= c_init_len;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= bus.load_en && !w_load_ok;
         if (bus.load_clear) begin
            r_prog_len <= '0;
         end else if (w_load_ok && (w_load_len > r_prog_len)) begin
            r_prog_len <= w_load_len;
         end
      end
   end

   assign bus.rd_ready  = w_rd_ready;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.read_data = r_read_data;
   assign bus.rd_oob    = r_rd_oob;
   assign bus.prog_len  = r_prog_len;
   assign bus.load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_rom_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_prog_rom_ctrl : scoreboard bench for prog_rom_ctrl (DEPTH=40)  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_prog_rom_ctrl;
   localparam logic [9:0] c_fill = 10'b0010000010;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   logic [10:0] exp_q [$];

   prog_rom_ctrl_if #(.DATA_WIDTH(10), .ADDR_WIDTH(10)) bus ();

   prog_rom_ctrl #(
      .DATA_WIDTH(10), .ADDR_WIDTH(10), .DEPTH(40), .INIT_LEN(0), .FILL_WORD(c_fill)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [9:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      tick();
      bus.load_en   = 1'b0;
   endtask

   // Single fetch with ack held high; the expected response goes to the scoreboard.
   task automatic fetch(input logic [9:0] a, input logic [9:0] d, input logic oob);
      bus.rd_req  = 1'b1;
      bus.address = a;
      bus.rd_ack  = 1'b1;
      exp_q.push_back({oob, d});
      tick();
      bus.rd_req  = 1'b0;
      tick();
   endtask

   // Monitor: every completed handshake consumes one expected response.
   always @(negedge clk) begin
      if (rst_n && bus.rd_valid && bus.rd_ack) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp: got %0h expected none", bus.read_data);
         end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("resp_data", bus.read_data, e[9:0]);
            chk("resp_oob", bus.rd_oob, e[10]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus.rd_req = 1'b0;  bus.address = '0;  bus.rd_ack = 1'b0;
      bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0; bus.load_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_data", bus.read_data, 0);
      chk("rst_oob", bus.rd_oob, 0);
      chk("rst_load_err", bus.load_err, 0);
      chk("rst_prog_len", bus.prog_len, 0);
      chk("rst_ready", bus.rd_ready, 1);
      tick();

      // Empty program: everything is out of bounds
      fetch(10'd0, c_fill, 1'b1);
      chk("empty_prog_len", bus.prog_len, 0);

      load(10'd0, 10'h370);
      load(10'd1, 10'h36D);
      chk("prog_len_2", bus.prog_len, 2);

      // Back-to-back fetch 0,1,2 with no bubble
      exp_q.push_back({1'b0, 10'h370});
      exp_q.push_back({1'b0, 10'h36D});
      exp_q.push_back({1'b1, c_fill});
      bus.rd_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.rd_req  = 1'b1;
         bus.address = 10'(i);
         tick();
         if (i == 2) bus.rd_req = 1'b0;
         @(negedge clk);
         chk("b2b_valid", bus.rd_valid, 1);
         #1;
      end
      tick();
      @(negedge clk);
      chk("b2b_drain", bus.rd_valid, 0);
      tick();

      // Stall: response held, further requests refused
      bus.rd_req = 1'b1; bus.address = 10'd1; bus.rd_ack = 1'b0;
      exp_q.push_back({1'b0, 10'h36D});
      tick();
      bus.address = 10'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stall_data", bus.read_data, 10'h36D);
         chk("stall_ready", bus.rd_ready, 0);
         tick();
      end
      bus.rd_req = 1'b0; bus.rd_ack = 1'b1;
      tick();
      @(negedge clk);
      chk("release_valid", bus.rd_valid, 0);
      tick();

      // Load has priority over a simultaneous fetch
      bus.load_en = 1'b1; bus.load_addr = 10'd2; bus.load_data = 10'h155;
      bus.rd_req = 1'b1;  bus.address = 10'd2;
      @(negedge clk);
      chk("load_blocks_ready", bus.rd_ready, 0);
      tick();
      bus.load_en = 1'b0;
      exp_q.push_back({1'b0, 10'h155});
      @(negedge clk);
      chk("not_accepted", bus.rd_valid, 0);
      chk("ready_after_load", bus.rd_ready, 1);
      tick();
      bus.rd_req = 1'b0;
      tick();
      chk("prog_len_3", bus.prog_len, 3);

      // Out-of-range load
      bus.load_en = 1'b1; bus.load_addr = 10'd45; bus.load_data = 10'h3FF;
      tick();
      bus.load_en = 1'b0;
      @(negedge clk);
      chk("load_err_pulse", bus.load_err, 1);
      chk("oor_prog_len", bus.prog_len, 3);
      tick();
      @(negedge clk);
      chk("load_err_drop", bus.load_err, 0);

      bus.load_clear = 1'b1;
      tick();
      bus.load_clear = 1'b0;
      chk("clear_prog_len", bus.prog_len, 0);
      fetch(10'd0, c_fill, 1'b1);

      // Clear beats length growth, but the write still lands
      bus.load_clear = 1'b1;
      load(10'd5, 10'h2AA);
      bus.load_clear = 1'b0;
      chk("clear_wins", bus.prog_len, 0);
      load(10'd6, 10'h011);
      chk("prog_len_7", bus.prog_len, 7);
      fetch(10'd5, 10'h2AA, 1'b0);

      // Top of memory and just past it
      load(10'd39, 10'h0F0);
      chk("prog_len_full", bus.prog_len, 40);
      fetch(10'd39, 10'h0F0, 1'b0);
      fetch(10'd40, c_fill, 1'b1);
      fetch(10'd1023, c_fill, 1'b1);

      // Asynchronous reset in mid-stall
      bus.rd_req = 1'b1; bus.address = 10'd1; bus.rd_ack = 1'b0;
      tick();
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("pre_rst_data", bus.read_data, 10'h36D);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus.rd_valid, 0);
      chk("async_rst_data", bus.read_data, 0);
      chk("async_rst_len", bus.prog_len, 0);
      tick();
      rst_n = 1'b1;
      bus.rd_ack = 1'b1;
      tick();
      tick();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/prog_rom_ctrl.md
Name: prog_rom_ctrl

Overview:
- Parametrised, loadable instruction memory with a registered fetch port. It is the next generation of the task program ROMs.
- Programs are written at run time through a load port instead of being hard-coded. Fetches use a req/ready/valid handshake with a one-entry output register that holds data under stall.
- A fetch beyond the loaded program length returns the HALT encoding and raises an out-of-bounds flag, so a runaway PC stops the CPU cleanly.

Parameters:
- DATA_WIDTH, 10, instruction word width.
- ADDR_WIDTH, 10, address width for fetch and load.
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- INIT_LEN, 0, value of prog_len after reset.
- FILL_WORD, 10'b0010000010, word returned for out-of-bounds fetches (HALT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  fetch request.
- address  in  ADDR_WIDTH  fetch address, sampled when the request is accepted.
- rd_ready  out  1  fetch request can be accepted this cycle.
- rd_valid  out  1  read_data holds a valid response.
- rd_ack  in  1  consumer accepts the current response.
- read_data  out  DATA_WIDTH  fetched word, registered.
- rd_oob  out  1  current response was out of bounds; qualified by rd_valid.
- load_en  in  1  write load_data to load_addr.
- load_addr  in  ADDR_WIDTH  load address.
- load_data  in  DATA_WIDTH  load word.
- load_clear  in  1  set prog_len to 0; memory contents unchanged.
- prog_len  out  ADDR_WIDTH+1  number of valid words (highest loaded address + 1).
- load_err  out  1  one-cycle pulse when load_addr >= DEPTH; the write is dropped.

Behaviour:
- Reset (async assert, release on the clock edge):
  - rd_valid = 0, read_data = 0, rd_oob = 0, load_err = 0, prog_len = INIT_LEN.
  - Memory array is not reset.
  - Reset asserted mid-fetch discards the pending response.
- rd_ready = !load_en && (!rd_valid || rd_ack). It is combinational.
- Fetch accept: rd_req && rd_ready. Latency is 1 cycle: on the next edge rd_valid = 1.
  - In bounds (address < prog_len and address < DEPTH): read_data = mem[address], rd_oob = 0.
  - Otherwise: read_data = FILL_WORD, rd_oob = 1.
- Response hold: while rd_valid && !rd_ack, read_data and rd_oob are frozen. New requests are refused because rd_ready = 0.
- Response release: rd_valid && rd_ack with no accepted request gives rd_valid = 0 next cycle; read_data keeps its last value.
- Back-to-back fetches: ack and a new accept in the same cycle give a fresh response next cycle with no bubble. Sustained throughput is 1 word per cycle.
- Load (load_en = 1), address in range:
  - mem[load_addr] <= load_data.
  - prog_len <= max(prog_len, load_addr + 1).
- Load (load_en = 1), load_addr >= DEPTH: no write, prog_len unchanged, load_err pulses for 1 cycle.
- Load priority: while load_en = 1 no fetch is accepted (rd_ready = 0). A response already in the output register stays valid and may still be acked.
- Read-after-write: a word written at edge N is returned by a fetch accepted at edge N+1 or later.
- load_clear: prog_len <= 0 next edge. It overrides an in-range load's length update in the same cycle, but the memory write still happens.
- Width rules:
  - prog_len is ADDR_WIDTH+1 bits so that a full memory (DEPTH = 2**ADDR_WIDTH) is representable.
  - Address comparisons are unsigned and zero-extended.
- Wrap-around: the fetch address never wraps internally; an address at or above DEPTH is always out of bounds.

Test Plan:
- Reset, then fetch address 0 with rd_ack held 1 -> rd_valid = 1 next cycle, read_data = 10'b0010000010, rd_oob = 1, prog_len = 0.
- Load 10'b1101110000 at address 0 and 10'b1101101101 at address 1, then fetch 0, 1, 2 back-to-back with rd_ack = 1:
  - Responses on 3 consecutive cycles: 0x370, 0x36D, then FILL_WORD with rd_oob = 1.
  - prog_len = 2.
- Stall: fetch address 1 with rd_ack = 0 for 4 cycles -> read_data = 0x36D is stable and rd_ready = 0 throughout. Assert rd_ack -> rd_valid falls the next cycle.
- Load and fetch requested in the same cycle -> rd_ready = 0 and the fetch is not accepted. The fetch is accepted the cycle after load_en drops and returns the newly written word.
- Out-of-range load: DEPTH = 40, load_addr = 45 -> load_err pulses for 1 cycle, prog_len unchanged. Then load_clear -> prog_len = 0 and fetch 0 returns FILL_WORD with rd_oob = 1.
- Assert rst_n low while rd_valid = 1 and in mid-stall -> rd_valid = 0 and read_data = 0 immediately, without waiting for a clock edge.
